// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared types and helpers for the display scan controller
package display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    function automatic int step_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// rtl/bcd_serial_converter.sv - serial double-dabble binary to BCD converter with overflow flag
module bcd_serial_converter
    import display_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [DATA_WIDTH-1:0]   value,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int SW = step_width(DATA_WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(DATA_WIDTH - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         work_q, work_d;
    logic [BW-1:0]         disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic                  pend_q, pend_d;
    logic [SW-1:0]         step_q, step_d;
    logic [BW-1:0]         adj;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        pend_d  = pend_q;
        step_d  = step_q;
        adj     = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = value;
                    work_d  = '0;
                    step_d  = '0;
                    pend_d  = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                // a bit leaving the top nibble means the value needs more digits than we have
                work_d  = {adj[BW-2:0], shift_q[DATA_WIDTH-1]};
                shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                pend_d  = pend_q | adj[BW-1];
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                disp_d  = work_q;
                ovf_d   = pend_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == UPDATE);
    // the fresh flag is already final during the done cycle
    assign overflow = done ? pend_q : ovf_q;
    assign bcd      = disp_q;

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - BCD conversion plus round-robin 7-segment digit scanner
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [3:0]            bcd_digit,
    output logic [NUM_DIGITS-1:0] digit_select
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] disp;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]              nib_q, nib_d;
    logic                    zero_run;

    bcd_serial_converter #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clock    (clock),
        .reset_n  (reset_n),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (disp)
    );

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        idx_d    = idx_q;
        sel_d    = '1;
        nib_d    = disp[3:0];
        zero_run = 1'b1;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        // walk from the top digit down so zero_run covers this digit and everything above it
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) begin
                sel_d[i] = 1'b0;
                if ((BLANK_ZEROS != 0) && (i > 0) && zero_run) begin
                    nib_d = BLANK_CODE;
                end else begin
                    nib_d = disp[4*i +: 4];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            sel_q <= ~(NUM_DIGITS'(1));
            nib_q <= 4'h0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sel_q <= sel_d;
            nib_q <= nib_d;
        end
    end

    assign digit_select = sel_q;
    assign bcd_digit    = nib_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - scoreboard bench for display_scan_controller
module tb_display_scan_controller;

    localparam int DW = 16;
    localparam int RD = 4;

    typedef struct packed {
        logic [19:0] digs;
        logic        ovf;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [DW-1:0] value = '0;

    logic       busy_w [3];
    logic       done_w [3];
    logic       ovf_w  [3];
    logic [3:0] bcd_w  [3];
    logic [4:0] sel0, sel1;
    logic [3:0] sel4;

    exp_t expq [3][$];
    int   dones [3];
    int   accepted = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    display_scan_controller #(.DATA_WIDTH(DW), .NUM_DIGITS(5), .REFRESH_DIV(RD), .BLANK_ZEROS(1)) dut0 (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy_w[0]), .done(done_w[0]), .overflow(ovf_w[0]),
        .bcd_digit(bcd_w[0]), .digit_select(sel0)
    );

    display_scan_controller #(.DATA_WIDTH(DW), .NUM_DIGITS(5), .REFRESH_DIV(RD), .BLANK_ZEROS(0)) dut1 (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy_w[1]), .done(done_w[1]), .overflow(ovf_w[1]),
        .bcd_digit(bcd_w[1]), .digit_select(sel1)
    );

    display_scan_controller #(.DATA_WIDTH(DW), .NUM_DIGITS(4), .REFRESH_DIV(RD), .BLANK_ZEROS(1)) dut2 (
        .clock(clock), .reset_n(reset_n), .value(value), .load(load),
        .busy(busy_w[2]), .done(done_w[2]), .overflow(ovf_w[2]),
        .bcd_digit(bcd_w[2]), .digit_select(sel4)
    );

    function automatic int nd_of(input int g);
        return (g == 2) ? 4 : 5;
    endfunction

    function automatic bit bz_of(input int g);
        return (g != 1);
    endfunction

    function automatic logic [4:0] sel_of(input int g);
        case (g)
            0:       return sel0;
            1:       return sel1;
            default: return {1'b1, sel4};
        endcase
    endfunction

    // decimal reference: digits by division, blanking by magnitude
    function automatic exp_t model(input int v, input int nd, input bit bz);
        exp_t m;
        int   lim = 1;
        int   v10;
        int   p = 1;
        int   d;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        v10    = v % lim;
        m.ovf  = (v >= lim);
        m.digs = '0;
        for (int i = 0; i < nd; i++) begin
            d = (v10 / p) % 10;
            if (bz && i > 0 && v10 < p) d = 15;
            m.digs[4*i +: 4] = 4'(d);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input int g, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s dut%0d got %0h expected %0h", nm, g, act, expv);
        end
    endtask

    task automatic scan(input int g, output logic [19:0] got);
        logic [4:0] s;
        got = '0;
        repeat (nd_of(g) * RD + RD) begin
            @(negedge clock);
            s = sel_of(g);
            for (int i = 0; i < nd_of(g); i++) begin
                if (!s[i]) got[4*i +: 4] = bcd_w[g];
            end
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        initial begin
            exp_t        e;
            logic [19:0] got;
            forever begin
                @(negedge clock);
                if (reset_n && done_w[g]) begin
                    dones[g]++;
                    if (expq[g].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done dut%0d got done=1 expected no done", g);
                    end else begin
                        e = expq[g].pop_front();
                        chk("overflow_at_done", g, int'(ovf_w[g]), int'(e.ovf));
                        repeat (3) @(negedge clock);
                        scan(g, got);
                        chk("scanned_digits", g, int'(got), int'(e.digs));
                    end
                end
            end
        end
    end

    task automatic do_load(input int v, input int extra_at, input int extra_v);
        int first_done = 0;
        int busy_ok = 1;
        @(negedge clock);
        value = DW'(v);
        load  = 1'b1;
        for (int g = 0; g < 3; g++) expq[g].push_back(model(v, nd_of(g), bz_of(g)));
        accepted++;
        for (int k = 1; k <= DW + 4; k++) begin
            @(negedge clock);
            if (k == 1) load = 1'b0;
            if (done_w[0] && first_done == 0) first_done = k;
            if (k <= DW + 1 && !busy_w[0]) busy_ok = 0;
            if (k == DW + 2 && busy_w[0]) busy_ok = 0;
            if (k == extra_at) begin
                value = DW'(extra_v);
                load  = 1'b1;
            end else if (k == extra_at + 1) begin
                load = 1'b0;
            end
        end
        chk("done_latency", 0, first_done, DW + 1);
        chk("busy_window", 0, busy_ok, 1);
        repeat (50) @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string nm);
        for (int g = 0; g < 3; g++) begin
            chk({nm, "_busy"}, g, int'(busy_w[g]), 0);
            chk({nm, "_done"}, g, int'(done_w[g]), 0);
            chk({nm, "_overflow"}, g, int'(ovf_w[g]), 0);
            chk({nm, "_select"}, g, int'(sel_of(g)), 'h1E);
            chk({nm, "_digit"}, g, int'(bcd_w[g]), 0);
        end
    endtask

    initial begin
        logic [19:0] got;
        int          v;
        int          e;
        for (int g = 0; g < 3; g++) dones[g] = 0;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        do_load(1234, 0, 0);
        do_load(7, 0, 0);
        do_load(0, 0, 0);
        do_load(1234, 5, 99);
        do_load(500, 17, 321);
        do_load(9999, 0, 0);
        do_load(10000, 0, 0);
        do_load(65535, 0, 0);

        // abort a conversion mid-scan while dut2 still holds overflow=1
        @(negedge clock);
        value = DW'(555);
        load  = 1'b1;
        @(negedge clock);
        load = 1'b0;
        repeat (7) @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        for (int g = 0; g < 3; g++) expq[g].delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            scan(g, got);
            chk("abort_display", g, int'(got), int'(model(0, nd_of(g), bz_of(g)).digs));
        end
        do_load(42, 0, 0);

        for (int n = 0; n < 8; n++) begin
            e = $urandom_range(1, 5);
            v = (e == 5) ? 65535 : (10 ** e) - 1;
            v = $urandom_range(0, v);
            do_load(v, 0, 0);
        end

        repeat (10) @(negedge clock);
        for (int g = 0; g < 3; g++) chk("done_count", g, dones[g], accepted);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
